pair_result_collector: RTL and testbench
========================================

// Module: pair_result_collector
// PURPOSE
//  Sink end of the signed operand/result stream: accepts (m, n) result pairs over a
//  valid/ready handshake and builds per-window statistics: count of m=1, saturating
//  signed sum of n, min, max. Publishes one report per window over a second valid/ready
//  handshake. Sits downstream of the signed function/task unit as its consumer/monitor.
// PARAMETERS
//  DW      4   width of signed result n
//  WINDOW  8   samples per window (>=2)
//  ACCW    6   width of signed saturating sum (>= DW)
//  CW      4   width of sample/m counters, must hold WINDOW ($clog2(WINDOW+1))
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     synchronous reset, active-high
//  in_valid     in   1     result pair valid
//  in_ready     out  1     collector can accept
//  in_m         in   1     result flag m
//  in_n         in   DW    signed result n
//  flush        in   1     close current window early
//  out_valid    out  1     report valid
//  out_ready    in   1     report consumer ready
//  out_samples  out  CW    samples in reported window
//  out_count_m  out  CW    samples with m=1
//  out_sum      out  ACCW  signed saturated sum of n
//  out_min      out  DW    signed minimum n
//  out_max      out  DW    signed maximum n
//  out_sat      out  1     sum saturated at least once in window (sticky per window)
// BEHAVIOUR
//  - Reset: state COLLECT, all accumulators and all out_* = 0, out_valid=0; in_ready=0
//    while rst high, 1 from first cycle after. rst mid-window discards partial window.
//  - States: COLLECT (in_ready=1, out_valid=0), REPORT (in_ready=0, out_valid=1).
//  - Accept = in_valid & in_ready. On accept: samples+1, count_m+in_m,
//    sum=sat(sum+sext(in_n)) clamped to [-2^(ACCW-1), 2^(ACCW-1)-1], out_sat|=clamp;
//    first sample of window loads min and max, later samples signed-compare.
//  - Cycles with in_valid=0 change nothing.
//  - COLLECT->REPORT when an accept makes samples==WINDOW, or flush=1 with
//    (samples>0 or accept this cycle); simultaneous accept+flush includes that sample.
//    flush with samples==0 and no accept is ignored. out_valid rises the cycle after
//    the closing edge; out_* registered, hold the full window result.
//  - REPORT: out_* stable while out_valid & !out_ready; in_valid, flush ignored.
//    On out_valid & out_ready: accumulators clear, COLLECT next cycle (in_ready=1 then).
//  - No combinational path in_valid->in_ready or out_ready->out_valid.
// STRUCTURE
//  - Package pair_result_pkg: state enum {COLLECT, REPORT}, sat_add function, default
//    DW/ACCW/WINDOW constants shared with producer and bench.
//  - Single sub-module natural: signed_sat_acc (register + sat add + sticky flag);
//    FSM, counters, min/max in top.
// TESTING (DW=4, WINDOW=8, ACCW=6)
//  - n=1,-2,3,-4,5,-6,7,-8, m=1,0,1,0,1,0,1,0 back-to-back -> out_valid 1 cycle after
//    8th accept; samples=8, count_m=4, sum=-4, min=-8, max=7, sat=0.
//  - eight n=-8 -> sum=-32 (clamped at 5th), sat=1, min=max=-8.
//  - out_ready=0 for 10 cycles with in_valid=1 -> out_* stable, in_ready=0, no counts;
//    out_ready=1 -> in_ready=1 next cycle, next window starts at samples=0.
//  - n=2,3,-1 then flush -> samples=3, sum=4, min=-1, max=3; flush at samples=0 -> no
//    report; flush coincident with 5th accept -> samples=5.
//  - rst after 5 samples -> all out_*=0; following 8 samples report samples=8 only.
//  - in_valid with random gaps (8 valid among 20 cycles) -> identical report to test 1.

Source files
------------

// File: rtl/pair_result_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pair_result_pkg
//  Purpose  : Shared types, default widths and the saturating-add helper used
//             by the pair result collector, its producer and its bench.
//  Contents : state_t      - collector state encoding (COLLECT / REPORT)
//             DEF_*        - default DW / WINDOW / ACCW values
//             sat_add()    - signed add clamped to an accw-bit range
//  Revision : 1.0 - initial release
// ============================================================================
package pair_result_pkg;

    localparam int DEF_DW     = 4;
    localparam int DEF_WINDOW = 8;
    localparam int DEF_ACCW   = 6;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    // Adds two sign-extended operands and clamps the result into the signed
    // range of an accw-bit register (accw <= 31). Bit 32 of the return value
    // flags that clamping happened; bits 31:0 hold the clamped sum.
    function automatic logic [32:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        accw
    );
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (accw - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (accw - 1));
        if (s > hi) begin
            return {1'b1, hi[31:0]};
        end else if (s < lo) begin
            return {1'b1, lo[31:0]};
        end else begin
            return {1'b0, s[31:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_sat_acc.sv
`default_nettype none
// ============================================================================
//  Module   : signed_sat_acc
//  Purpose  : Signed saturating accumulator with a sticky saturation flag.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous active-high reset
//             i_clear  - clear accumulator and flag (start of a new window)
//             i_en     - add i_data this cycle
//             i_data   - signed addend, DW bits
//             o_acc    - signed accumulated sum, ACCW bits
//             o_sat    - set once any add in the window clamped
//  Revision : 1.0 - initial release
// ============================================================================
module signed_sat_acc
    import pair_result_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int ACCW = DEF_ACCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_en,
    input  logic signed [DW-1:0]   i_data,
    output logic signed [ACCW-1:0] o_acc,
    output logic                   o_sat
);

    logic signed [ACCW-1:0] r_acc;
    logic                   r_sat;
    logic signed [31:0]     w_acc_ext;
    logic signed [31:0]     w_data_ext;
    logic [32:0]            w_res;
    logic                   w_unused_hi;

    assign w_acc_ext  = 32'(r_acc);
    assign w_data_ext = 32'(i_data);
    assign w_res      = sat_add(w_acc_ext, w_data_ext, ACCW);

    // The clamped result always fits in ACCW bits; upper bits are only sign copies.
    assign w_unused_hi = ^w_res[31:ACCW];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_res[ACCW-1:0];
            r_sat <= r_sat | w_res[32];
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/pair_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : pair_result_collector
//  Purpose  : Consumes (m, n) result pairs and publishes one statistics
//             report per window: sample count, count of m=1, saturating
//             signed sum of n, signed min/max of n, sticky saturation flag.
//  Ports    : clk, rst                 - clock / synchronous active-high reset
//             in_valid/in_ready        - input pair handshake
//             in_m, in_n               - result flag and signed result
//             flush                    - close a non-empty window early
//             out_valid/out_ready      - report handshake
//             out_samples, out_count_m - window sample / m=1 counts
//             out_sum, out_sat         - saturated sum and sticky clamp flag
//             out_min, out_max         - signed extremes of n
//  Revision : 1.0 - initial release
// ============================================================================
module pair_result_collector
    import pair_result_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int WINDOW = DEF_WINDOW,
    parameter int ACCW   = DEF_ACCW,
    parameter int CW     = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_m,
    input  logic signed [DW-1:0]   in_n,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_samples,
    output logic [CW-1:0]          out_count_m,
    output logic signed [ACCW-1:0] out_sum,
    output logic signed [DW-1:0]   out_min,
    output logic signed [DW-1:0]   out_max,
    output logic                   out_sat
);

    localparam logic [CW-1:0] c_window_cnt = CW'(WINDOW);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_samples;
    logic [CW-1:0]        r_count_m;
    logic signed [DW-1:0] r_min;
    logic signed [DW-1:0] r_max;
    logic [CW-1:0]        w_samples_inc;
    logic                 w_accept;
    logic                 w_clear;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready      = (r_state == COLLECT) && !rst;
    assign out_valid     = (r_state == REPORT);
    assign w_accept      = in_valid && in_ready;
    assign w_samples_inc = r_samples + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            COLLECT: begin
                // A flush coinciding with an accept still counts that sample,
                // and a flush on an empty window is ignored.
                if ((w_accept && (w_samples_inc == c_window_cnt)) ||
                    (flush && (w_accept || (r_samples != '0)))) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    w_clear     = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
            end
        endcase
    end

    // Counters and extremes; they stay frozen in REPORT because no accept
    // can happen there, so they double as the report registers.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_samples <= '0;
            r_count_m <= '0;
            r_min     <= '0;
            r_max     <= '0;
        end else if (w_accept) begin
            r_samples <= w_samples_inc;
            r_count_m <= r_count_m + CW'(in_m);
            if (r_samples == '0) begin
                r_min <= in_n;
                r_max <= in_n;
            end else begin
                if (in_n < r_min) begin
                    r_min <= in_n;
                end
                if (in_n > r_max) begin
                    r_max <= in_n;
                end
            end
        end
    end

    signed_sat_acc #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_en    (w_accept),
        .i_data  (in_n),
        .o_acc   (out_sum),
        .o_sat   (out_sat)
    );

    assign out_samples = r_samples;
    assign out_count_m = r_count_m;
    assign out_min     = r_min;
    assign out_max     = r_max;

endmodule
`default_nettype wire

// File: tb/tb_pair_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pair_result_collector
//  Purpose  : Self-checking bench for pair_result_collector with a window-level
//             reference model and hand-computed report expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pair_result_collector;
    import pair_result_pkg::*;

    localparam int DW     = DEF_DW;
    localparam int WINDOW = DEF_WINDOW;
    localparam int ACCW   = DEF_ACCW;
    localparam int CW     = $clog2(WINDOW + 1);
    localparam int SUM_HI = (1 << (ACCW - 1)) - 1;
    localparam int SUM_LO = -(1 << (ACCW - 1));

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_m;
    logic signed [DW-1:0]   in_n;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [CW-1:0]          out_samples;
    logic [CW-1:0]          out_count_m;
    logic signed [ACCW-1:0] out_sum;
    logic signed [DW-1:0]   out_min;
    logic signed [DW-1:0]   out_max;
    logic                   out_sat;

    pair_result_collector #(
        .DW     (DW),
        .WINDOW (WINDOW),
        .ACCW   (ACCW),
        .CW     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_m        (in_m),
        .in_n        (in_n),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_samples (out_samples),
        .out_count_m (out_count_m),
        .out_sum     (out_sum),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_sat     (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model (window statistics) ----------------
    bit m_rep   = 1'b0;
    int m_cnt   = 0;
    int m_cm    = 0;
    int m_sum   = 0;
    int m_min   = 0;
    int m_max   = 0;
    bit m_sat   = 1'b0;
    bit started = 1'b0;

    always @(posedge clk) begin : model
        int s;
        int n;
        started <= 1'b1;
        if (rst) begin
            m_rep <= 1'b0; m_cnt <= 0; m_cm <= 0; m_sum <= 0;
            m_min <= 0; m_max <= 0; m_sat <= 1'b0;
        end else if (m_rep) begin
            if (out_ready) begin
                m_rep <= 1'b0; m_cnt <= 0; m_cm <= 0; m_sum <= 0;
                m_min <= 0; m_max <= 0; m_sat <= 1'b0;
            end
        end else begin
            if (in_valid) begin
                n = int'(in_n);
                s = m_sum + n;
                if (s > SUM_HI) begin
                    s = SUM_HI;
                    m_sat <= 1'b1;
                end else if (s < SUM_LO) begin
                    s = SUM_LO;
                    m_sat <= 1'b1;
                end
                m_sum <= s;
                m_cnt <= m_cnt + 1;
                m_cm  <= m_cm + int'(in_m);
                m_min <= (m_cnt == 0 || n < m_min) ? n : m_min;
                m_max <= (m_cnt == 0 || n > m_max) ? n : m_max;
            end
            if ((in_valid && (m_cnt + 1 == WINDOW)) || (flush && (in_valid || m_cnt > 0)))
                m_rep <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mdl_in_ready", in_ready, (!rst && !m_rep) ? 1 : 0);
            chk("mdl_out_valid", out_valid, m_rep ? 1 : 0);
            if (m_rep) begin
                chk("mdl_samples", out_samples, m_cnt);
                chk("mdl_count_m", out_count_m, m_cm);
                chk("mdl_sum", $signed(out_sum), m_sum);
                chk("mdl_min", $signed(out_min), m_min);
                chk("mdl_max", $signed(out_max), m_max);
                chk("mdl_sat", out_sat, m_sat ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int t1n [8] = '{1, -2, 3, -4, 5, -6, 7, -8};

    task automatic send(input logic m, input int n, input logic fl);
        in_valid = 1'b1;
        in_m     = m;
        in_n     = n[DW-1:0];
        flush    = fl;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_t1(input int first, input int count);
        for (int i = first; i < first + count; i++)
            send((i % 2) == 0, t1n[i], 1'b0);
    endtask

    task automatic wait_rep(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) return;
            @(posedge clk); #1;
        end
        chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_rep(input string nm, input int s, input int cm, input int sum,
                             input int mn, input int mx, input int sat);
        chk({nm, "_samples"}, out_samples, s);
        chk({nm, "_count_m"}, out_count_m, cm);
        chk({nm, "_sum"}, $signed(out_sum), sum);
        chk({nm, "_min"}, $signed(out_min), mn);
        chk({nm, "_max"}, $signed(out_max), mx);
        chk({nm, "_sat"}, out_sat, sat);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        check_rep(nm, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [19:0] gap;
        int k;
        rst = 1'b1; in_valid = 1'b0; in_m = 1'b0; in_n = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1);

        // Alternating pattern, back-to-back
        send_t1(0, 8);
        chk("t1_latency_valid", out_valid, 1);
        check_rep("t1", 8, 4, -4, -8, 7, 0);
        drain();
        chk("t1_ready_after", in_ready, 1);

        // Saturating sum
        for (int i = 0; i < 8; i++) send(1'b1, -8, 1'b0);
        wait_rep("t2");
        check_rep("t2", 8, 8, -32, -8, -8, 1);
        drain();

        // Back-pressure on the report
        send_t1(0, 8);
        wait_rep("t3");
        in_valid = 1'b1; in_m = 1'b1; in_n = 4'sd3; flush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_ready", in_ready, 0);
            chk("t3_hold_sum", $signed(out_sum), -4);
            chk("t3_hold_samples", out_samples, 8);
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();
        chk("t3_ready_next", in_ready, 1);
        chk("t3_valid_clear", out_valid, 0);
        send_t1(0, 7);
        chk("t3_not_early", out_valid, 0);
        send_t1(7, 1);
        chk("t3_second_valid", out_valid, 1);
        chk("t3_second_samples", out_samples, 8);
        drain();

        // Flush cases
        send(1'b1, 2, 1'b0); send(1'b0, 3, 1'b0); send(1'b0, -1, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t4_flush_valid", out_valid, 1);
        check_rep("t4", 3, 1, 4, -1, 3, 0);
        drain();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_empty_flush", out_valid, 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) send(1'b0, 1, 1'b0);
        send(1'b0, 1, 1'b1);
        chk("t4_coinc_valid", out_valid, 1);
        check_rep("t4c", 5, 0, 5, 1, 1, 0);
        drain();

        // Reset mid-window
        send_t1(0, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_ready", in_ready, 0);
        check_zero("t5");
        rst = 1'b0;
        send_t1(0, 7);
        chk("t5_not_early", out_valid, 0);
        send_t1(7, 1);
        chk("t5_valid", out_valid, 1);
        check_rep("t5", 8, 4, -4, -8, 7, 0);
        drain();

        // Gappy input, same data as the first test
        gap = 20'b1010_0100_1001_0000_1101;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (gap[i]) begin
                send((k % 2) == 0, t1n[k], 1'b0);
                k++;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("t6_valid", out_valid, 1);
        check_rep("t6", 8, 4, -4, -8, 7, 0);
        drain();

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
